// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the shared 32x8 program/data memory: CPU has fixed
// priority, a saturating wait counter forces the host through after MAX_WAIT lost edges.
module mem_arbiter #(
    parameter int AW       = 5,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_,

    input  logic          cpu_req,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,

    input  logic          host_req,
    input  logic          host_wr,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,

    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          owner
);

    localparam int            CW       = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_SAT = CW'(MAX_WAIT);

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          mem_rd_q, mem_rd_d;
    logic          mem_wr_q, mem_wr_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    owner_e        owner_q, owner_d;
    logic          rd_pend_q, rd_pend_d;
    owner_e        rd_owner_q, rd_owner_d;

    logic          host_force;
    logic          cpu_win;
    logic          host_win;
    logic          xfer;
    logic          win_wr;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    // Grants are held low during reset so no transfer can be counted
    // against a requester whose state is being cleared.
    always_comb begin
        host_force = (wait_cnt_q == WAIT_SAT);
        cpu_win    = 1'b0;
        host_win   = 1'b0;
        if (rst_) begin
            if (cpu_req && host_req) begin
                host_win = host_force;
                cpu_win  = !host_force;
            end else begin
                cpu_win  = cpu_req;
                host_win = host_req;
            end
        end
    end

    assign cpu_gnt  = cpu_win;
    assign host_gnt = host_win;
    assign xfer     = cpu_win | host_win;

    always_comb begin
        win_wr    = cpu_wr;
        win_addr  = cpu_addr;
        win_wdata = cpu_wdata;
        if (host_win) begin
            win_wr    = host_wr;
            win_addr  = host_addr;
            win_wdata = host_wdata;
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (host_win) begin
            wait_cnt_d = '0;
        end else if (host_req && (wait_cnt_q != WAIT_SAT)) begin
            wait_cnt_d = wait_cnt_q + CW'(1);
        end
    end

    always_comb begin
        mem_rd_d    = xfer & ~win_wr;
        mem_wr_d    = xfer & win_wr;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        owner_d     = owner_q;
        if (xfer) begin
            mem_addr_d  = win_addr;
            mem_wdata_d = win_wdata;
            owner_d     = host_win ? OWN_HOST : OWN_CPU;
        end
    end

    // The memory samples mem_rd one edge after the command is issued; data is then
    // valid for the following cycle, so the return tag is the command delayed once.
    always_comb begin
        rd_pend_d  = mem_rd_q;
        rd_owner_d = owner_q;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wait_cnt_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            owner_q     <= OWN_CPU;
            rd_pend_q   <= 1'b0;
            rd_owner_q  <= OWN_CPU;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            owner_q     <= owner_d;
            rd_pend_q   <= rd_pend_d;
            rd_owner_q  <= rd_owner_d;
        end
    end

    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign owner     = owner_q;

    always_comb begin
        cpu_rvalid  = rd_pend_q && (rd_owner_q == OWN_CPU);
        host_rvalid = rd_pend_q && (rd_owner_q == OWN_HOST);
        cpu_rdata   = cpu_rvalid  ? mem_rdata : '0;
        host_rdata  = host_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 32x8 memory and a read-return scoreboard.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_;
    logic       cpu_req, cpu_wr, cpu_gnt, cpu_rvalid;
    logic [4:0] cpu_addr;
    logic [7:0] cpu_wdata, cpu_rdata;
    logic       host_req, host_wr, host_gnt, host_rvalid;
    logic [4:0] host_addr;
    logic [7:0] host_wdata, host_rdata;
    logic       mem_rd, mem_wr, owner;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;

    typedef struct packed {
        logic       own;
        logic [7:0] data;
    } rsp_t;

    rsp_t       sb[$];
    logic [7:0] mem [32];
    int         tests = 0;
    int         fails = 0;
    int         stray = 0;

    mem_arbiter #(.AW(5), .DW(8), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_(rst_),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected response for every rvalid the DUT presents.
    always @(negedge clk) begin
        rsp_t e;
        if (cpu_rvalid && host_rvalid) chk("both_rvalid", 1, 0);
        if (!cpu_rvalid)  chk("cpu_rdata_idle", {24'h0, cpu_rdata}, 0);
        if (!host_rvalid) chk("host_rdata_idle", {24'h0, host_rdata}, 0);
        if (cpu_rvalid || host_rvalid) begin
            if (sb.size() == 0) begin
                stray++;
                chk("unexpected_rvalid", {31'h0, host_rvalid}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("rsp_owner", {31'h0, host_rvalid}, {31'h0, e.own});
                chk("rsp_data", {24'h0, host_rvalid ? host_rdata : cpu_rdata}, {24'h0, e.data});
            end
        end
    end

    task automatic drive(input logic cr, input logic cw, input logic [4:0] ca, input logic [7:0] cd,
                         input logic hr, input logic hw, input logic [4:0] ha, input logic [7:0] hd);
        cpu_req = cr; cpu_wr = cw; cpu_addr = ca; cpu_wdata = cd;
        host_req = hr; host_wr = hw; host_addr = ha; host_wdata = hd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_h4[10];
        bit req_h6[7];
        bit exp_h6[7];
        int n_rv;
        exp_h4 = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        req_h6 = '{1, 1, 1, 0, 0, 1, 1};
        exp_h6 = '{0, 0, 0, 0, 0, 0, 1};
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        mem[5] = 8'h3C; mem[2] = 8'h11; mem[3] = 8'h22;
        mem_rdata = 8'h00;

        // Reset state with both requests asserted
        rst_ = 1'b0;
        drive(1, 0, 5'd7, 8'hFF, 1, 1, 5'd9, 8'hEE);
        #3;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_host_gnt", host_gnt, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_owner", owner, 0);
        step();
        rst_ = 1'b1;
        idle(2);

        // CPU read of addr 5
        drive(1, 0, 5'd5, 8'h00, 0, 0, 0, 0);
        @(negedge clk);
        chk("t2_cpu_gnt", cpu_gnt, 1);
        chk("t2_host_gnt", host_gnt, 0);
        sb.push_back('{own: 1'b0, data: 8'h3C});
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t2_mem_rd", mem_rd, 1);
        chk("t2_mem_wr", mem_wr, 0);
        chk("t2_mem_addr", mem_addr, 5);
        chk("t2_owner", owner, 0);
        step();
        @(negedge clk);
        chk("t2_cpu_rvalid", cpu_rvalid, 1);
        chk("t2_host_rvalid", host_rvalid, 0);
        chk("t2_idle_mem_rd", mem_rd, 0);
        chk("t2_hold_addr", mem_addr, 5);
        idle(2);

        // Host write then read of addr 31
        drive(0, 0, 0, 0, 1, 1, 5'd31, 8'hA5);
        @(negedge clk);
        chk("t3_host_gnt_wr", host_gnt, 1);
        step();
        drive(0, 0, 0, 0, 1, 0, 5'd31, 8'h00);
        @(negedge clk);
        chk("t3_mem_wr", mem_wr, 1);
        chk("t3_mem_wdata", mem_wdata, 8'hA5);
        chk("t3_mem_addr", mem_addr, 31);
        chk("t3_owner_wr", owner, 1);
        chk("t3_host_gnt_rd", host_gnt, 1);
        sb.push_back('{own: 1'b1, data: 8'hA5});
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t3_mem_rd", mem_rd, 1);
        chk("t3_mem_wr_off", mem_wr, 0);
        chk("t3_owner_rd", owner, 1);
        step();
        @(negedge clk);
        chk("t3_host_rvalid", host_rvalid, 1);
        chk("t3_owner_hold", owner, 1);
        idle(2);

        // Both read on consecutive edges: CPU addr 2, then host addr 3
        drive(1, 0, 5'd2, 0, 1, 0, 5'd3, 0);
        @(negedge clk);
        chk("t5_cpu_first", cpu_gnt, 1);
        chk("t5_host_waits", host_gnt, 0);
        sb.push_back('{own: 1'b0, data: 8'h11});
        step();
        drive(0, 0, 0, 0, 1, 0, 5'd3, 0);
        @(negedge clk);
        chk("t5_host_second", host_gnt, 1);
        sb.push_back('{own: 1'b1, data: 8'h22});
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t5_cpu_rvalid", cpu_rvalid, 1);
        step();
        @(negedge clk);
        chk("t5_host_rvalid", host_rvalid, 1);
        idle(2);

        // Both request every cycle: C,C,C,C,H,C,C,C,C,H
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 5'd10, 8'h77, 1, 1, 5'd11, 8'h88);
            @(negedge clk);
            chk($sformatf("t4_host_gnt[%0d]", i), host_gnt, exp_h4[i]);
            chk($sformatf("t4_cpu_gnt[%0d]", i), cpu_gnt, !exp_h4[i]);
            if (i > 0) chk($sformatf("t4_owner[%0d]", i), owner, exp_h4[i-1]);
            step();
        end
        idle(2);

        // Host drops at wait_cnt=3; count holds, one more loss forces a host win
        for (int i = 0; i < 7; i++) begin
            drive(1, 1, 5'd12, 8'h55, req_h6[i], 1, 5'd11, 8'h88);
            @(negedge clk);
            chk($sformatf("t6_host_gnt[%0d]", i), host_gnt, exp_h6[i]);
            chk($sformatf("t6_cpu_gnt[%0d]", i), cpu_gnt, !exp_h6[i]);
            step();
        end
        idle(2);

        // Reset while a CPU read is in flight
        drive(1, 0, 5'd5, 0, 0, 0, 0, 0);
        step();
        drive(1, 0, 5'd5, 0, 1, 0, 5'd3, 0);
        #2;
        rst_ = 1'b0;
        #1;
        chk("t1_mem_rd", mem_rd, 0);
        chk("t1_mem_addr", mem_addr, 0);
        chk("t1_mem_wdata", mem_wdata, 0);
        chk("t1_owner", owner, 0);
        chk("t1_cpu_gnt", cpu_gnt, 0);
        chk("t1_host_gnt", host_gnt, 0);
        chk("t1_cpu_rvalid", cpu_rvalid, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_ = 1'b1;
        n_rv = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (cpu_rvalid || host_rvalid) n_rv++;
            step();
        end
        chk("t1_no_rvalid_after_rst", n_rv, 0);

        chk("sb_drained", sb.size(), 0);
        chk("no_stray_rvalid", stray, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
